// File: rtl/mul_div_unit_if.sv
// Start/result handshake between the control unit and the
// iterative multiply/divide engine.
interface mul_div_unit_if #(
    parameter int WIDTH = 32
) ();
    logic             alu_start;
    logic [4:0]       alu_func;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] result;
    logic             alu_valid;
    logic             busy;

    modport master (
        output alu_start, alu_func, op_a, op_b,
        input  result, alu_valid, busy
    );

    modport slave (
        input  alu_start, alu_func, op_a, op_b,
        output result, alu_valid, busy
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative 32-cycle shift-add multiplier and restoring
// signed divider sharing one {hi, lo} working register.
module mul_div_unit #(
    parameter int         WIDTH    = 32,
    parameter logic [4:0] FUNC_MUL = 5'b00010,
    parameter logic [4:0] FUNC_DIV = 5'b00011
) (
    input  logic           clk,
    input  logic           rst,
    mul_div_unit_if.slave  io
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             is_div;
    logic             neg;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] opnd;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ok;
    logic [WIDTH-1:0] nxt_hi;
    logic [WIDTH-1:0] nxt_lo;
    logic [WIDTH-1:0] res_n;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             last;

    assign a_mag = io.op_a[WIDTH-1] ? -io.op_a : io.op_a;
    assign b_mag = io.op_b[WIDTH-1] ? -io.op_b : io.op_b;
    assign last  = (cnt == CW'(WIDTH - 1));

    // Multiply: hi accumulates, lo shifts the multiplier out
    // and the product low bits in. Divide: hi is the partial
    // remainder, lo shifts the dividend out and quotient in.
    always_comb begin
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        div_shift = {hi, lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd};
        div_ok    = ~div_diff[WIDTH];
        if (is_div) begin
            nxt_hi = div_ok ? div_diff[WIDTH-1:0]
                            : div_shift[WIDTH-1:0];
            nxt_lo = {lo[WIDTH-2:0], div_ok};
            res_n  = neg ? -nxt_lo : nxt_lo;
        end else begin
            nxt_hi = mul_sum[WIDTH:1];
            nxt_lo = {mul_sum[0], lo[WIDTH-1:1]};
            res_n  = nxt_lo;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= '0;
            is_div       <= 1'b0;
            neg          <= 1'b0;
            hi           <= '0;
            lo           <= '0;
            opnd         <= '0;
            io.result    <= '0;
            io.alu_valid <= 1'b0;
            io.busy      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    io.alu_valid <= 1'b0;
                    io.busy      <= 1'b0;
                    if (io.alu_start) begin
                        cnt     <= '0;
                        io.busy <= 1'b1;
                        hi      <= '0;
                        if (io.alu_func == FUNC_MUL) begin
                            is_div <= 1'b0;
                            lo     <= io.op_b;
                            opnd   <= io.op_a;
                            state  <= CALC;
                        end else if (io.alu_func == FUNC_DIV &&
                                     io.op_b != '0) begin
                            is_div <= 1'b1;
                            neg    <= io.op_a[WIDTH-1] ^
                                      io.op_b[WIDTH-1];
                            lo     <= a_mag;
                            opnd   <= b_mag;
                            state  <= CALC;
                        end else begin
                            io.result    <=
                                (io.alu_func == FUNC_DIV) ? '1 : '0;
                            io.alu_valid <= 1'b1;
                            state        <= DONE;
                        end
                    end
                end
                CALC: begin
                    hi  <= nxt_hi;
                    lo  <= nxt_lo;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        io.result    <= res_n;
                        io.alu_valid <= 1'b1;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    io.alu_valid <= 1'b0;
                    io.busy      <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit: results,
// latency, busy window, ignored starts and mid-op reset.
module tb_mul_div_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;

    mul_div_unit_if #(.WIDTH(32)) bus ();

    mul_div_unit dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h",
                     tag, got, exp);
        end
    endtask

    // Called #1 after a rising edge; start is sampled at the
    // next edge (cycle 0). Loop index c is the cycle number.
    task automatic run(input string       tag,
                       input logic [4:0]  f,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [31:0] er,
                       input int          el,
                       input int          poke,
                       input int          rcyc);
        int vcyc = 0;
        int bad  = 0;
        bus.alu_start = 1'b1;
        bus.alu_func  = f;
        bus.op_a      = a;
        bus.op_b      = b;
        @(posedge clk); #1;
        bus.alu_start = 1'b0;
        bus.op_a      = ~a;
        bus.op_b      = b + 32'd1;
        for (int c = 1; c <= 40; c++) begin
            if (rcyc != 0 && c == rcyc + 1) begin
                chk({tag, "/rst_valid"},
                    32'(bus.alu_valid), 32'd0);
                chk({tag, "/rst_busy"}, 32'(bus.busy), 32'd0);
                chk({tag, "/rst_result"}, bus.result, 32'd0);
                chk({tag, "/busy_win"}, 32'(bad), 32'd0);
                chk({tag, "/no_valid"}, 32'(vcyc), 32'd0);
                rst = 1'b1;
                return;
            end
            if (c <= el && !bus.busy) bad++;
            if (bus.alu_valid) begin
                vcyc = c;
                break;
            end
            bus.alu_start = (poke != 0 && c == poke);
            if (poke != 0 && c == poke) begin
                bus.op_a = 32'd3;
                bus.op_b = 32'd3;
            end
            if (rcyc == c) rst = 1'b0;
            @(posedge clk); #1;
        end
        chk({tag, "/latency"}, 32'(vcyc), 32'(el));
        chk({tag, "/result"}, bus.result, er);
        chk({tag, "/busy_win"}, 32'(bad), 32'd0);
        bus.alu_start = 1'b0;
        @(posedge clk); #1;
        chk({tag, "/valid_drop"}, 32'(bus.alu_valid), 32'd0);
        chk({tag, "/busy_drop"}, 32'(bus.busy), 32'd0);
        chk({tag, "/result_hold"}, bus.result, er);
    endtask

    initial begin
        bus.alu_start = 1'b0;
        bus.alu_func  = 5'd0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_result", bus.result, 32'd0);
        chk("reset_valid", 32'(bus.alu_valid), 32'd0);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        rst = 1'b1;

        run("mul7x6", 5'b00010, 32'd7, 32'd6,
            32'd42, 33, 0, 0);
        run("mul_ignore", 5'b00010, 32'd7, 32'd6,
            32'd42, 33, 10, 0);
        run("mul_neg1x3", 5'b00010, 32'hFFFF_FFFF, 32'd3,
            32'hFFFF_FFFD, 33, 0, 0);
        run("mul_wrap", 5'b00010, 32'h0001_0000,
            32'h0001_0000, 32'd0, 33, 0, 0);
        run("div_m7_2", 5'b00011, 32'hFFFF_FFF9, 32'd2,
            32'hFFFF_FFFD, 33, 0, 0);
        run("div_100_7", 5'b00011, 32'd100, 32'd7,
            32'd14, 33, 0, 0);
        run("div_m100_7", 5'b00011, 32'hFFFF_FF9C, 32'd7,
            32'hFFFF_FFF2, 33, 0, 0);
        run("div_min_m1", 5'b00011, 32'h8000_0000,
            32'hFFFF_FFFF, 32'h8000_0000, 33, 0, 0);
        run("div_by0", 5'b00011, 32'd5, 32'd0,
            32'hFFFF_FFFF, 1, 0, 0);
        run("bad_func", 5'b00100, 32'd9, 32'd9,
            32'd0, 1, 0, 0);

        rst           = 1'b0;
        bus.alu_start = 1'b1;
        bus.alu_func  = 5'b00010;
        bus.op_a      = 32'd7;
        bus.op_b      = 32'd6;
        @(posedge clk); #1;
        bus.alu_start = 1'b0;
        rst           = 1'b1;
        chk("rst_wins_busy", 32'(bus.busy), 32'd0);
        chk("rst_wins_valid", 32'(bus.alu_valid), 32'd0);
        @(posedge clk); #1;
        chk("rst_wins_idle", 32'(bus.busy), 32'd0);

        run("div_abort", 5'b00011, 32'd100, 32'd7,
            32'd14, 33, 0, 15);
        run("div_after_rst", 5'b00011, 32'd100, 32'd7,
            32'd14, 33, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end
endmodule
